multi_counter: RTL and testbench
================================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits counted and displayed (legal 1..8).
REQ-002 Parameter DIV_W, default 32, prescaler counter width in bits.
REQ-003 Parameter SCAN_W, default 17, display refresh divider width; one digit slot lasts 2^SCAN_W cycles.
REQ-004 multi_counter_port_clk  in  1  single system clock; all state on rising edge.
REQ-005 multi_counter_port_rst  in  1  asynchronous, active-high reset of all state.
REQ-006 multi_counter_port_clk_rst  in  1  synchronous clear of prescaler and scan divider only.
REQ-007 multi_counter_port_clk_factor  in  5  count tick period exponent; tick every 2^factor cycles.
REQ-008 multi_counter_port_en  in  1  count enable.
REQ-009 multi_counter_port_up  in  1  1 = count up, 0 = count down.
REQ-010 multi_counter_port_load  in  1  synchronous load strobe.
REQ-011 multi_counter_port_load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-012 multi_counter_port_blank_lz  in  1  leading-zero blanking enable.
REQ-013 multi_counter_port_count  out  4*DIGITS  current BCD count.
REQ-014 multi_counter_port_tc  out  1  one-cycle terminal-count pulse on wrap.
REQ-015 multi_counter_port_ssd  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-016 multi_counter_port_an  out  8  active-low digit anodes.

Function
REQ-017 Prescaler: free-running DIV_W-bit counter, +1 every cycle, wraps at all-ones; cleared to 0 by clk_rst.
REQ-018 Tick: high for exactly one cycle when prescaler bits [factor-1:0] are all ones; factor=0 -> tick every cycle; factor >= DIV_W treated as DIV_W.
REQ-019 Priority per cycle: load > (tick & en) count > hold.
REQ-020 Load: count <= load_val next edge, regardless of tick/en; any digit >9 loads as 9; tc stays 0.
REQ-021 Up count: digit 0 +1; digit at 9 goes to 0 and carries to next digit; all-nines -> all-zeros with tc=1 that cycle.
REQ-022 Down count: digit 0 -1; digit at 0 goes to 9 and borrows; all-zeros -> all-nines with tc=1 that cycle.
REQ-023 tc registered, asserted only in the cycle following the wrapping tick, never for two consecutive cycles unless wrap repeats.
REQ-024 up changes take effect at next tick; no counting when en=0.
REQ-025 Scan: SCAN_W-bit divider; at all-ones digit index advances 0,1..DIGITS-1,0; clk_rst clears divider and index.
REQ-026 an: registered; bit[index]=0, all others 1; bits >= DIGITS always 1.
REQ-027 ssd: registered decode of digit[index]: 0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000.
REQ-028 Blanking: blank_lz=1 and digit[index]=0 and all higher digits 0 and index!=0 -> ssd=1111111.
REQ-029 an/ssd lag index/count by exactly one cycle.

Reset
REQ-030 rst=1 asynchronously forces: prescaler 0, scan divider 0, index 0, count 0, tc 0, an=11111110, ssd=1000000; holds while asserted, counting resumes from 0 after release, including mid-operation.

Verification
REQ-031 rst=1 10 cycles, release -> count=0, tc=0, an=8'hFE, ssd=7'b1000000 immediately after assertion.
REQ-032 DIGITS=2, factor=0, en=1, up=1 from 0 -> count 99 after 99 cycles, 00 with tc=1 one cycle at 100th tick.
REQ-033 factor=3, up=0, load_val=0x05 load -> decrements every 8 cycles; 00 -> 99 with tc pulse; en=0 holds.
REQ-034 load=1 concurrent with tick, load_val=0x3C -> count=0x39, no increment that cycle, tc=0.
REQ-035 SCAN_W=2, DIGITS=4, count=0x0042, blank_lz=1 -> an cycles FE,FD,FB,F7 every 4 cycles; ssd 2,4,blank,blank; blank_lz=0 shows 0 on digits 2,3.
REQ-036 clk_rst pulse mid-count -> prescaler/scan restart, index 0, count unchanged.

Source files
------------

// File: rtl/multi_counter.sv
// Multi-digit BCD up/down counter with a programmable tick prescaler and a
// multiplexed, active-low seven-segment display driver.
module multi_counter #(
   parameter int DIGITS = 4,
   parameter int DIV_W  = 32,
   parameter int SCAN_W = 17
) (
   input  logic                multi_counter_port_clk,
   input  logic                multi_counter_port_rst,
   input  logic                multi_counter_port_clk_rst,
   input  logic [4:0]          multi_counter_port_clk_factor,
   input  logic                multi_counter_port_en,
   input  logic                multi_counter_port_up,
   input  logic                multi_counter_port_load,
   input  logic [4*DIGITS-1:0] multi_counter_port_load_val,
   input  logic                multi_counter_port_blank_lz,
   output logic [4*DIGITS-1:0] multi_counter_port_count,
   output logic                multi_counter_port_tc,
   output logic [6:0]          multi_counter_port_ssd,
   output logic [7:0]          multi_counter_port_an
);
   localparam int CW = 4*DIGITS;

   logic [DIV_W-1:0]  r_presc;
   logic [SCAN_W-1:0] r_scan;
   logic [2:0]        r_idx;
   logic [CW-1:0]     r_count;
   logic              r_tc;
   logic [7:0]        r_an;
   logic [6:0]        r_ssd;

   logic [DIV_W-1:0]  w_mask;
   logic              w_tick;
   logic [CW-1:0]     w_load_sat;
   logic [CW-1:0]     w_next;
   logic              w_wrap;
   logic [3:0]        w_digit;
   logic              w_higher_zero;
   logic              w_blank;
   logic [7:0]        w_an;
   logic [6:0]        w_seg;

   // Factors at or above DIV_W set every mask bit, which clamps them naturally.
   // NOTE: every always_comb output is given a default first so no path infers a latch.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DIV_W; i++)
         w_mask[i] = ({27'd0, multi_counter_port_clk_factor} > i);
      w_tick = &(r_presc | ~w_mask);
   end

   always_comb begin : bcd_step
      logic carry;
      w_load_sat = '0;
      w_next     = r_count;
      carry      = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         w_load_sat[4*d +: 4] = (multi_counter_port_load_val[4*d +: 4] > 4'd9) ?
                                4'd9 : multi_counter_port_load_val[4*d +: 4];
         if (carry) begin
            if (multi_counter_port_up) begin
               if (r_count[4*d +: 4] == 4'd9) begin
                  w_next[4*d +: 4] = 4'd0;
               end else begin
                  w_next[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                  carry            = 1'b0;
               end
            end else begin
               if (r_count[4*d +: 4] == 4'd0) begin
                  w_next[4*d +: 4] = 4'd9;
               end else begin
                  w_next[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                  carry            = 1'b0;
               end
            end
         end
      end
      w_wrap = carry;
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge multi_counter_port_clk or posedge multi_counter_port_rst) begin
      if (multi_counter_port_rst)
         r_presc <= '0;
      else if (multi_counter_port_clk_rst)
         r_presc <= '0;
      else
         r_presc <= r_presc + DIV_W'(1);
   end

   always_ff @(posedge multi_counter_port_clk or posedge multi_counter_port_rst) begin
      if (multi_counter_port_rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else if (multi_counter_port_load) begin
         r_count <= w_load_sat;
         r_tc    <= 1'b0;
      end else if (w_tick && multi_counter_port_en) begin
         r_count <= w_next;
         r_tc    <= w_wrap;
      end else begin
         r_tc    <= 1'b0;
      end
   end

   always_ff @(posedge multi_counter_port_clk or posedge multi_counter_port_rst) begin
      if (multi_counter_port_rst) begin
         r_scan <= '0;
         r_idx  <= 3'd0;
      end else if (multi_counter_port_clk_rst) begin
         r_scan <= '0;
         r_idx  <= 3'd0;
      end else begin
         r_scan <= r_scan + SCAN_W'(1);
         if (&r_scan)
            r_idx <= (r_idx == 3'(DIGITS-1)) ? 3'd0 : r_idx + 3'd1;
      end
   end

   // A digit blanks only when it and every more significant digit are zero.
   always_comb begin
      w_digit       = 4'd0;
      w_higher_zero = 1'b1;
      w_an          = 8'hFF;
      for (int d = 0; d < DIGITS; d++) begin
         if (3'(d) == r_idx) begin
            w_digit = r_count[4*d +: 4];
            w_an[d] = 1'b0;
         end else if ((3'(d) > r_idx) && (r_count[4*d +: 4] != 4'd0)) begin
            w_higher_zero = 1'b0;
         end
      end
      w_blank = multi_counter_port_blank_lz && (w_digit == 4'd0) &&
                w_higher_zero && (r_idx != 3'd0);
      case (w_digit)
         4'd0:    w_seg = 7'b1000000;
         4'd1:    w_seg = 7'b1111001;
         4'd2:    w_seg = 7'b0100100;
         4'd3:    w_seg = 7'b0110000;
         4'd4:    w_seg = 7'b0011001;
         4'd5:    w_seg = 7'b0010010;
         4'd6:    w_seg = 7'b0000010;
         4'd7:    w_seg = 7'b1111000;
         4'd8:    w_seg = 7'b0000000;
         4'd9:    w_seg = 7'b0010000;
         default: w_seg = 7'b1111111;
      endcase
      if (w_blank)
         w_seg = 7'b1111111;
   end

   always_ff @(posedge multi_counter_port_clk or posedge multi_counter_port_rst) begin
      if (multi_counter_port_rst) begin
         r_an  <= 8'hFE;
         r_ssd <= 7'b1000000;
      end else begin
         r_an  <= w_an;
         r_ssd <= w_seg;
      end
   end

   assign multi_counter_port_count = r_count;
   assign multi_counter_port_tc    = r_tc;
   assign multi_counter_port_an    = r_an;
   assign multi_counter_port_ssd   = r_ssd;

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: a 2-digit and a 4-digit instance share
// control inputs; a cycle model pushes expected outputs that are popped after each edge.
module tb_multi_counter;
   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        clk_rst  = 1'b0;
   logic [4:0]  factor   = 5'd0;
   logic        en       = 1'b0;
   logic        up       = 1'b1;
   logic        load     = 1'b0;
   logic [7:0]  load_val2 = 8'h00;
   logic [15:0] load_val4 = 16'h0000;
   logic        blank_lz = 1'b0;

   logic [7:0]  count2;
   logic        tc2;
   logic [6:0]  ssd2;
   logic [7:0]  an2;
   logic [15:0] count4;
   logic        tc4;
   logic [6:0]  ssd4;
   logic [7:0]  an4;

   always #5 clk = ~clk;

   multi_counter #(.DIGITS(2), .DIV_W(8), .SCAN_W(2)) u_dut2 (
      .multi_counter_port_clk        (clk),
      .multi_counter_port_rst        (rst),
      .multi_counter_port_clk_rst    (clk_rst),
      .multi_counter_port_clk_factor (factor),
      .multi_counter_port_en         (en),
      .multi_counter_port_up         (up),
      .multi_counter_port_load       (load),
      .multi_counter_port_load_val   (load_val2),
      .multi_counter_port_blank_lz   (blank_lz),
      .multi_counter_port_count      (count2),
      .multi_counter_port_tc         (tc2),
      .multi_counter_port_ssd        (ssd2),
      .multi_counter_port_an         (an2)
   );

   multi_counter #(.DIGITS(4), .DIV_W(8), .SCAN_W(2)) u_dut4 (
      .multi_counter_port_clk        (clk),
      .multi_counter_port_rst        (rst),
      .multi_counter_port_clk_rst    (clk_rst),
      .multi_counter_port_clk_factor (factor),
      .multi_counter_port_en         (en),
      .multi_counter_port_up         (up),
      .multi_counter_port_load       (load),
      .multi_counter_port_load_val   (load_val4),
      .multi_counter_port_blank_lz   (blank_lz),
      .multi_counter_port_count      (count4),
      .multi_counter_port_tc         (tc4),
      .multi_counter_port_ssd        (ssd4),
      .multi_counter_port_an         (an4)
   );

   typedef struct packed {
      logic [7:0]  cnt2;
      logic        tc2;
      logic [15:0] cnt4;
      logic        tc4;
      logic [7:0]  an4;
      logic [6:0]  ssd4;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   logic [7:0]  m_presc;
   logic [1:0]  m_scan;
   int          m_idx;
   logic [31:0] m_cnt2;
   logic [31:0] m_cnt4;
   logic        m_tc2;
   logic        m_tc4;
   logic [7:0]  m_an;
   logic [6:0]  m_ssd;
   logic        m_tick;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0:       seg = 7'b1000000;
         1:       seg = 7'b1111001;
         2:       seg = 7'b0100100;
         3:       seg = 7'b0110000;
         4:       seg = 7'b0011001;
         5:       seg = 7'b0010010;
         6:       seg = 7'b0000010;
         7:       seg = 7'b1111000;
         8:       seg = 7'b0000000;
         9:       seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   function automatic int bcd2int(input logic [31:0] v, input int n);
      int r = 0;
      for (int d = n-1; d >= 0; d--) r = r*10 + int'(v[4*d +: 4]);
      return r;
   endfunction

   function automatic logic [31:0] int2bcd(input int x, input int n);
      logic [31:0] r = '0;
      int t = x;
      for (int d = 0; d < n; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Counting is modelled as integer arithmetic modulo 10^n.
   task automatic m_count(inout logic [31:0] cnt, output logic tc, input int n,
                          input logic [31:0] lv);
      int lim;
      int v;
      lim = 1;
      for (int d = 0; d < n; d++) lim = lim * 10;
      tc = 1'b0;
      if (load) begin
         cnt = '0;
         for (int d = 0; d < n; d++) cnt[4*d +: 4] = (lv[4*d +: 4] > 4'd9) ? 4'd9 : lv[4*d +: 4];
      end else if (m_tick && en) begin
         v = bcd2int(cnt, n);
         if (up) begin
            v = v + 1;
            if (v == lim) begin v = 0; tc = 1'b1; end
         end else if (v == 0) begin
            v = lim - 1; tc = 1'b1;
         end else begin
            v = v - 1;
         end
         cnt = int2bcd(v, n);
      end
   endtask

   task automatic model_reset();
      m_presc = '0; m_scan = '0; m_idx = 0;
      m_cnt2 = '0; m_cnt4 = '0; m_tc2 = 1'b0; m_tc4 = 1'b0;
      m_an = 8'hFE; m_ssd = 7'b1000000;
      sb.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven; push the result.
   task automatic model_push();
      logic [8:0] mask;
      int         eff;
      int         dig;
      bit         hz;
      eff    = (factor > 5'd8) ? 8 : int'(factor);
      mask   = (9'd1 << eff) - 9'd1;
      m_tick = ((m_presc & mask[7:0]) == mask[7:0]);
      dig    = int'(m_cnt4[4*m_idx +: 4]);
      hz     = 1'b1;
      for (int d = m_idx + 1; d < 4; d++) if (m_cnt4[4*d +: 4] != 4'd0) hz = 1'b0;
      m_an        = 8'hFF;
      m_an[m_idx] = 1'b0;
      m_ssd       = (blank_lz && dig == 0 && hz && m_idx != 0) ? 7'b1111111 : seg(dig);
      m_count(m_cnt2, m_tc2, 2, {24'd0, load_val2});
      m_count(m_cnt4, m_tc4, 4, {16'd0, load_val4});
      if (clk_rst) begin
         m_scan = '0; m_idx = 0; m_presc = '0;
      end else begin
         if (m_scan == 2'd3) m_idx = (m_idx + 1) % 4;
         m_scan  = m_scan + 2'd1;
         m_presc = m_presc + 8'd1;
      end
      sb.push_back('{cnt2: m_cnt2[7:0], tc2: m_tc2, cnt4: m_cnt4[15:0], tc4: m_tc4,
                     an4: m_an, ssd4: m_ssd});
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (count2 !== 8'h00 || count4 !== 16'h0000 || tc2 !== 1'b0 || an4 !== 8'hFE || ssd4 !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_assert: count2=%h count4=%h tc2=%b an4=%h ssd4=%b want 00 0000 0 fe 1000000",
                  count2, count4, tc2, an4, ssd4);
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (count2 !== 8'h00 || tc2 !== 1'b0 || an4 !== 8'hFE || ssd4 !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_hold: count2=%h tc2=%b an4=%h ssd4=%b", count2, tc2, an4, ssd4);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_count_up_wrap();
      en = 1'b1; up = 1'b1; factor = 5'd0;
      for (int i = 1; i <= 102; i++) begin
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || tc2 !== e.tc2 || count4 !== e.cnt4 || tc4 !== e.tc4) begin
            failures++;
            $display("FAIL up_wrap[%0d]: count2=%h tc2=%b count4=%h tc4=%b want %h %b %h %b",
                     i, count2, tc2, count4, tc4, e.cnt2, e.tc2, e.cnt4, e.tc4);
         end
         if (i == 99) begin
            checks++;
            if (count2 !== 8'h99 || tc2 !== 1'b0) begin
               failures++;
               $display("FAIL up_at_99: count2=%h tc2=%b want 99 0", count2, tc2);
            end
         end
         if (i == 100) begin
            checks++;
            if (count2 !== 8'h00 || tc2 !== 1'b1) begin
               failures++;
               $display("FAIL up_wrap_tc: count2=%h tc2=%b want 00 1", count2, tc2);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_down_factor3();
      int tc_seen;
      tc_seen = 0;
      up = 1'b0; factor = 5'd3; en = 1'b1;
      for (int i = 0; i < 88; i++) begin
         load      = (i == 0);
         load_val2 = 8'h05;
         load_val4 = 16'h0005;
         en        = (i < 64);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || tc2 !== e.tc2 || count4 !== e.cnt4 || tc4 !== e.tc4) begin
            failures++;
            $display("FAIL down_f3[%0d]: count2=%h tc2=%b count4=%h tc4=%b want %h %b %h %b",
                     i, count2, tc2, count4, tc4, e.cnt2, e.tc2, e.cnt4, e.tc4);
         end
         if (tc2 === 1'b1) tc_seen++;
         @(negedge clk);
      end
      load = 1'b0;
      checks++;
      if (tc_seen != 1) begin
         failures++;
         $display("FAIL down_tc_pulses: saw %0d tc pulses want 1", tc_seen);
      end
   endtask

   task automatic test_load_tick();
      factor = 5'd0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load      = (i < 2);
         load_val2 = (i == 0) ? 8'h99 : 8'h3C;
         load_val4 = (i == 0) ? 16'h9999 : 16'hA3C5;
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || tc2 !== e.tc2 || count4 !== e.cnt4 || tc4 !== e.tc4) begin
            failures++;
            $display("FAIL load_tick[%0d]: count2=%h tc2=%b count4=%h tc4=%b want %h %b %h %b",
                     i, count2, tc2, count4, tc4, e.cnt2, e.tc2, e.cnt4, e.tc4);
         end
         if (i == 1) begin
            checks++;
            if (count2 !== 8'h39 || count4 !== 16'h9395 || tc2 !== 1'b0 || tc4 !== 1'b0) begin
               failures++;
               $display("FAIL load_sat: count2=%h count4=%h tc2=%b tc4=%b want 39 9395 0 0",
                        count2, count4, tc2, tc4);
            end
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   task automatic test_scan();
      en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         load      = (i == 0);
         load_val2 = 8'h42;
         load_val4 = 16'h0042;
         clk_rst   = (i == 1);
         blank_lz  = (i < 22);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (an4 !== e.an4 || ssd4 !== e.ssd4 || count4 !== e.cnt4) begin
            failures++;
            $display("FAIL scan[%0d]: an4=%h ssd4=%b count4=%h want %h %b %h",
                     i, an4, ssd4, count4, e.an4, e.ssd4, e.cnt4);
         end
         if (i > 2 && an4 === 8'hFB) begin
            checks++;
            if (ssd4 !== (blank_lz ? 7'b1111111 : 7'b1000000)) begin
               failures++;
               $display("FAIL scan_digit2[%0d]: ssd4=%b blank_lz=%b", i, ssd4, blank_lz);
            end
         end
         @(negedge clk);
      end
      load = 1'b0; clk_rst = 1'b0;
   endtask

   task automatic test_clk_rst();
      factor = 5'd3; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 40; i++) begin
         clk_rst = (i == 13);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || tc2 !== e.tc2 || an4 !== e.an4 || ssd4 !== e.ssd4) begin
            failures++;
            $display("FAIL clk_rst[%0d]: count2=%h tc2=%b an4=%h ssd4=%b want %h %b %h %b",
                     i, count2, tc2, an4, ssd4, e.cnt2, e.tc2, e.an4, e.ssd4);
         end
         @(negedge clk);
      end
      clk_rst = 1'b0;
   endtask

   task automatic test_factor_clamp();
      factor = 5'd31; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 262; i++) begin
         clk_rst = (i == 0);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || tc2 !== e.tc2 || count4 !== e.cnt4) begin
            failures++;
            $display("FAIL factor_clamp[%0d]: count2=%h count4=%h want %h %h",
                     i, count2, count4, e.cnt2, e.cnt4);
         end
         @(negedge clk);
      end
      clk_rst = 1'b0;
   endtask

   task automatic test_mid_reset();
      factor = 5'd0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 5; i++) begin
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || count4 !== e.cnt4) begin
            failures++;
            $display("FAIL pre_reset[%0d]: count2=%h count4=%h want %h %h", i, count2, count4, e.cnt2, e.cnt4);
         end
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (count2 !== 8'h00 || count4 !== 16'h0000 || tc2 !== 1'b0 || an4 !== 8'hFE || ssd4 !== 7'b1000000) begin
         failures++;
         $display("FAIL mid_reset: count2=%h count4=%h tc2=%b an4=%h ssd4=%b", count2, count4, tc2, an4, ssd4);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 5; i++) begin
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (count2 !== e.cnt2 || count4 !== e.cnt4 || an4 !== e.an4) begin
            failures++;
            $display("FAIL post_reset[%0d]: count2=%h count4=%h an4=%h want %h %h %h",
                     i, count2, count4, an4, e.cnt2, e.cnt4, e.an4);
         end
         if (i == 1) begin
            checks++;
            if (count2 !== 8'h01) begin
               failures++;
               $display("FAIL resume_from_zero: count2=%h want 01", count2);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_count_up_wrap();
      test_down_factor3();
      test_load_tick();
      test_scan();
      test_clk_rst();
      test_factor_clamp();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
